harvest_sense_sequencer: RTL

//  Sequences one sensing cycle of the microgreen classifier:
//    1. ultrasonic ping,
//    2. camera frame capture,
//    3. BNN inference,
//    4. harvest decision.

---
 rtl/harvest_pkg.sv | 18 +
 rtl/seq_timeout_timer.sv | 30 +++
 rtl/harvest_sense_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/harvest_pkg.sv
// Shared definitions for the harvest sensing sequencer: FSM state encoding and fault bit indices.
package harvest_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PING       = 3'd1,
    S_WAIT_PING  = 3'd2,
    S_ARM        = 3'd3,
    S_WAIT_FRAME = 3'd4,
    S_INFER      = 3'd5,
    S_WAIT_INFER = 3'd6,
    S_DECIDE     = 3'd7
  } state_t;

  localparam int FAULT_PING  = 0;
  localparam int FAULT_FRAME = 1;

endpackage

// File: rtl/seq_timeout_timer.sv
// Shared stage timer: clears on load, otherwise counts up and sticks at all-ones.
// expired is combinational from the count; ena low freezes the count.
module seq_timeout_timer #(
  parameter int TMR_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [TMR_W-1:0] limit,
  output logic             expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      if (load) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + 1'b1;
      end
    end
  end

  assign expired = (count == limit - 1'b1);

endmodule

// File: rtl/harvest_sense_sequencer.sv
// One sensing cycle (ping, frame, BNN, decide) with stage timeouts and N-positive buzzer confirmation.
// Pulses are state decodes gated by ena; buzzer lags harvest_cnt by one cycle. UART_OVERRIDE_EN ORs alert_in into buzzer.
module harvest_sense_sequencer
  import harvest_pkg::*;
#(
  parameter int TMR_W         = 21,
  parameter int PING_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT = 1500000,
  parameter int CONFIRM_N     = 3,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             run,
  input  logic             fault_clr,
  output logic             ping_req,
  input  logic             ping_done,
  output logic             frame_arm,
  input  logic             frame_done,
  output logic             infer_start,
  input  logic             infer_done,
  input  logic             prediction,
  input  logic             alert_in,
  output logic             buzzer,
  output logic             busy,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] harvest_cnt
);

  localparam logic [TMR_W-1:0] PING_LIM  = TMR_W'(PING_TIMEOUT);
  localparam logic [TMR_W-1:0] FRAME_LIM = TMR_W'(FRAME_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CONFIRM_N);

  state_t           state, state_nxt;
  logic             tmr_load;
  logic             tmr_expired;
  logic [TMR_W-1:0] tmr_limit;
  logic [1:0]       fault_set;
  logic             cnt_upd;
  logic             confirmed;
  logic             buzzer_nxt;

  assign tmr_limit = (state == S_WAIT_FRAME) ? FRAME_LIM : PING_LIM;

  seq_timeout_timer #(.TMR_W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (tmr_load),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  // A done pulse beats a simultaneous timeout, so no fault is raised in that case.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    fault_set = 2'b00;
    cnt_upd   = 1'b0;
    case (state)
      S_IDLE: if (run) state_nxt = S_PING;
      S_PING: begin
        state_nxt = S_WAIT_PING;
        tmr_load  = 1'b1;
      end
      S_WAIT_PING: begin
        if (ping_done) begin
          state_nxt = S_ARM;
        end else if (tmr_expired) begin
          fault_set[FAULT_PING] = 1'b1;
          state_nxt             = S_ARM;
        end
      end
      S_ARM: begin
        state_nxt = S_WAIT_FRAME;
        tmr_load  = 1'b1;
      end
      S_WAIT_FRAME: begin
        if (frame_done) begin
          state_nxt = S_INFER;
        end else if (tmr_expired) begin
          fault_set[FAULT_FRAME] = 1'b1;
          state_nxt              = S_IDLE;
        end
      end
      S_INFER:      state_nxt = S_WAIT_INFER;
      S_WAIT_INFER: if (infer_done) state_nxt = S_DECIDE;
      S_DECIDE: begin
        cnt_upd   = 1'b1;
        state_nxt = run ? S_PING : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign confirmed = (harvest_cnt == CNT_MAX);

`ifdef UART_OVERRIDE_EN
  assign buzzer_nxt = confirmed | alert_in;
`else
  logic unused_alert_in;
  assign unused_alert_in = alert_in;
  assign buzzer_nxt      = confirmed;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fault       <= 2'b00;
      harvest_cnt <= '0;
      buzzer      <= 1'b0;
    end else if (ena) begin
      state  <= state_nxt;
      fault  <= (fault & ~{2{fault_clr}}) | fault_set;
      buzzer <= buzzer_nxt;
      if (cnt_upd) begin
        if (!prediction) begin
          harvest_cnt <= '0;
        end else if (harvest_cnt != CNT_MAX) begin
          harvest_cnt <= harvest_cnt + 1'b1;
        end
      end
    end
  end

  assign ping_req    = (state == S_PING) & ena;
  assign infer_start = (state == S_INFER) & ena;
  assign frame_arm   = (state == S_ARM) | (state == S_WAIT_FRAME);
  assign busy        = (state != S_IDLE);

endmodule
